// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA modular exponentiation path.
// States, Montgomery op codes and default operand widths.
package rsa_pkg;

  localparam int DEF_WIDTH     = 2048;
  localparam int DEF_EXP_WIDTH = 2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } me_state_e;

  typedef enum logic [2:0] {
    OP_TO_MB,
    OP_TO_X1,
    OP_SQR,
    OP_MUL,
    OP_FROM
  } me_op_e;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer in Montgomery form.
// Drives an external MONT_MUL through registered operand ports.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     r2,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     mm_x,
  output logic [WIDTH-1:0]     mm_y,
  output logic [WIDTH-1:0]     mm_n,
  output logic                 mm_rst,
  input  logic                 mm_finish,
  input  logic [WIDTH-1:0]     mm_result
);

  localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0]    BIT_TOP = CW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  me_state_e state_q, state_d;
  me_op_e    op_q, op_d;

  logic [CW-1:0]        bit_q, bit_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     r2_q, r2_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     mm_x_q, mm_x_d;
  logic [WIDTH-1:0]     mm_y_q, mm_y_d;
  logic [WIDTH-1:0]     mm_n_q, mm_n_d;
  logic                 err_q, err_d;

  // State and datapath registers; modulus lives in mm_n_q, base in mm_x_q.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_TO_MB;
      bit_q   <= '0;
      exp_q   <= '0;
      r2_q    <= '0;
      mb_q    <= '0;
      x_q     <= '0;
      res_q   <= '0;
      mm_x_q  <= '0;
      mm_y_q  <= '0;
      mm_n_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bit_q   <= bit_d;
      exp_q   <= exp_d;
      r2_q    <= r2_d;
      mb_q    <= mb_d;
      x_q     <= x_d;
      res_q   <= res_d;
      mm_x_q  <= mm_x_d;
      mm_y_q  <= mm_y_d;
      mm_n_q  <= mm_n_d;
      err_q   <= err_d;
    end
  end

  // Next state, op sequencing and operand staging for the next multiply.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bit_d   = bit_q;
    exp_d   = exp_q;
    r2_d    = r2_q;
    mb_d    = mb_q;
    x_d     = x_q;
    res_d   = res_q;
    mm_x_d  = mm_x_q;
    mm_y_d  = mm_y_q;
    mm_n_d  = mm_n_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          op_d    = OP_TO_MB;
          bit_d   = BIT_TOP;
          exp_d   = exponent;
          r2_d    = r2;
          mb_d    = '0;
          x_d     = '0;
          mm_x_d  = base;
          mm_y_d  = r2;
          mm_n_d  = modulus;
          err_d   = ~modulus[0];
        end
      end
      ST_ISSUE: begin
        if (err_q) begin
          state_d = ST_DONE;
          res_d   = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mm_finish) begin
          state_d = ST_NEXT;
          if (op_q == OP_TO_MB) mb_d = mm_result;
          else                  x_d  = mm_result;
        end
      end
      ST_NEXT: begin
        state_d = ST_ISSUE;
        unique case (1'b1)
          (op_q == OP_TO_MB): begin
            op_d   = OP_TO_X1;
            mm_x_d = ONE;
            mm_y_d = r2_q;
          end
          (op_q == OP_TO_X1): begin
            op_d   = OP_SQR;
            mm_x_d = x_q;
            mm_y_d = x_q;
          end
          (op_q == OP_SQR) && exp_q[bit_q]: begin
            op_d   = OP_MUL;
            mm_x_d = x_q;
            mm_y_d = mb_q;
          end
          (op_q == OP_FROM): begin
            state_d = ST_DONE;
            res_d   = x_q;
          end
          default: begin
            // Bit finished (SQR with 0 bit, or MUL): step down or leave.
            mm_x_d = x_q;
            if (bit_q == '0) begin
              op_d   = OP_FROM;
              mm_y_d = ONE;
            end else begin
              op_d   = OP_SQR;
              bit_d  = bit_q - CW'(1);
              mm_y_d = x_q;
            end
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                  (state_q == ST_NEXT);
  assign done   = (state_q == ST_DONE);
  assign err    = (state_q == ST_DONE) && err_q;
  assign result = res_q;
  assign mm_rst = (state_q != ST_WAIT);
  assign mm_x   = mm_x_q;
  assign mm_y   = mm_y_q;
  assign mm_n   = mm_n_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural MONT_MUL.
// WIDTH=8 (R=256), EXP_WIDTH=4, multiplier latency 10.
module tb_mod_exp_ctrl;

  localparam int W  = 8;
  localparam int EW = 4;
  localparam int L  = 10;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0, modulus = '0, r2 = '0;
  logic [EW-1:0] exponent = '0;
  logic          busy, done, err, mm_rst;
  logic [W-1:0]  result, mm_x, mm_y, mm_n;
  logic          mm_finish = 1'b0;
  logic [W-1:0]  mm_result = '0;

  int checks = 0;
  int failures = 0;
  int falls = 0;
  int dones = 0;
  int cyc;
  logic prev_rst = 1'b1;

  int           mcnt = 0;
  logic [W-1:0] cap_x, cap_y, cap_n;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .base      (base),
    .modulus   (modulus),
    .r2        (r2),
    .exponent  (exponent),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .mm_x      (mm_x),
    .mm_y      (mm_y),
    .mm_n      (mm_n),
    .mm_rst    (mm_rst),
    .mm_finish (mm_finish),
    .mm_result (mm_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // x*y*256^-1 mod n by search; n is odd whenever this is called.
  function automatic logic [W-1:0] mm(input logic [W-1:0] x, y, n);
    int p;
    p = (int'(x) * int'(y)) % int'(n);
    for (int z = 0; z < int'(n); z++)
      if (((z * 256) % int'(n)) == p) return W'(z);
    return '1;
  endfunction

  // Behavioural MONT_MUL: finish rises L cycles after mm_rst falls.
  always @(posedge clk) begin
    if (mm_rst) begin
      mcnt      <= 0;
      mm_finish <= 1'b0;
    end else begin
      if (mcnt == 0) begin
        cap_x <= mm_x;
        cap_y <= mm_y;
        cap_n <= mm_n;
      end
      if (mcnt == L - 1) begin
        chk("mm_ops_stable", {8'd0, mm_x, mm_y, mm_n},
            {8'd0, cap_x, cap_y, cap_n});
        mm_finish <= 1'b1;
        mm_result <= mm(mm_x, mm_y, mm_n);
      end
      mcnt <= mcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (prev_rst && !mm_rst) falls++;
    prev_rst = mm_rst;
    if (done) dones++;
  end

  task automatic kick(input logic [W-1:0] b, input logic [EW-1:0] e,
                      input logic [W-1:0] m, input logic [W-1:0] rr);
    repeat (2) @(negedge clk);
    base = b; exponent = e; modulus = m; r2 = rr;
    start = 1'b1;
    falls = 0;
    dones = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    base = 8'hA5; exponent = 4'hF; modulus = 8'h3C; r2 = 8'h77;
  endtask

  // cyc counts cycles after the sampling edge of start (ISSUE = 1).
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_mm_rst", mm_rst, 1);
    chk("rst_mm_ops", {mm_x, mm_y, mm_n}, 0);
    sys_rst_n = 1'b1;

    // 5^3 mod 7 = 125 mod 7 = 6; 3+4+2 = 9 ops of 13 cycles.
    kick(8'd5, 4'd3, 8'd7, 8'd2);
    chk("t1_busy", busy, 1);
    chk("t1_mm_n", mm_n, 7);
    wait_done(cyc);
    chk("t1_cycles", cyc, 118);
    chk("t1_result", result, 6);
    chk("t1_err", err, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_falls", falls, 9);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", done, 0);
    chk("t1_hold", result, 6);

    // Exponent zero: result 1, 3+4+0 = 7 ops.
    kick(8'd5, 4'd0, 8'd7, 8'd2);
    wait_done(cyc);
    chk("t2_cycles", cyc, 92);
    chk("t2_result", result, 1);
    chk("t2_falls", falls, 7);

    // Base zero with nonzero exponent gives 0.
    kick(8'd0, 4'd9, 8'd7, 8'd2);
    wait_done(cyc);
    chk("t2b_result", result, 0);
    chk("t2b_falls", falls, 9);

    // Preload a nonzero result so the error path visibly clears it.
    kick(8'd5, 4'd3, 8'd7, 8'd2);
    wait_done(cyc);
    chk("t3_pre", result, 6);

    // Even modulus: ISSUE then DONE, no multiply launched.
    kick(8'd5, 4'd3, 8'd6, 8'd4);
    chk("t3_busy", busy, 1);
    wait_done(cyc);
    chk("t3_cycles", cyc, 2);
    chk("t3_err", err, 1);
    chk("t3_result", result, 0);
    chk("t3_falls", falls, 0);

    // Second start mid-run is dropped: 3^5 = 243 = 5 mod 7.
    kick(8'd3, 4'd5, 8'd7, 8'd2);
    repeat (30) @(posedge clk);
    @(negedge clk);
    base = 8'd6; exponent = 4'd1; modulus = 8'd7; r2 = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("t4_result", result, 5);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_dones", dones, 1);
    chk("t4_err", err, 0);

    // Reset while the multiplier is running.
    kick(8'd5, 4'd3, 8'd7, 8'd2);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", mm_rst, 0);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_mm_rst", mm_rst, 1);
    chk("t5_done", done, 0);
    chk("t5_result", result, 0);
    chk("t5_mm_x", mm_x, 0);
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_done", dones, 0);

    // Restart: 3^5 = 243 = 1 mod 11, so 3^15 = 1; 3+4+4 = 11 ops.
    kick(8'd3, 4'd15, 8'd11, 8'd9);
    wait_done(cyc);
    chk("t6_cycles", cyc, 144);
    chk("t6_result", result, 1);
    chk("t6_err", err, 0);
    chk("t6_falls", falls, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
